// File: rtl/bus_memory_system.sv
// -----------------------------------------------------------------------------
// bus_memory_system
//   Synchronous RAM behind a req/ready bus handshake. Wait states are
//   programmable, and a memory-mapped console TX FIFO drains onto a
//   valid/ready byte stream.
//
// Optional feature macro: MEM_WRITE_PROTECT_EN
//   Defined   : RAM writes to ROM_BASE..ROM_LIMIT are dropped. bus_ready still
//               pulses, and wp_error pulses with it.
//   Undefined : every RAM write commits, and wp_error is tied to 0.
//
// Ports
//   clock       in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   bus_req     in   access request, sampled only while idle
//   bus_we      in   1 = write, 0 = read (latched with bus_req)
//   bus_addr    in   access address (latched with bus_req)
//   bus_wdata   in   write data (latched with bus_req)
//   bus_rdata   out  read data, held until the next read completes
//   bus_ready   out  one-cycle completion pulse
//   tx_valid    out  console FIFO not empty
//   tx_data     out  console FIFO head byte (registered)
//   tx_ready    in   consumer accepts the head byte when tx_valid & tx_ready
//   tx_overflow out  sticky flag: a console byte was dropped on a full FIFO
//   wp_error    out  pulses with bus_ready when a protected write is blocked
//
// Memory map
//   MMIO_BASE   : console data register. Writes push a byte; reads return 0.
//   MMIO_BASE+1 : status register {.., overflow, empty, full}. Writes clear
//                 the overflow flag.
//   Every other address aliases into RAM through its low DEPTH_LOG2 bits.
// -----------------------------------------------------------------------------
module bus_memory_system #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    DEPTH_LOG2  = 16,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] MMIO_BASE   = 'hF200,
    parameter int                    FIFO_LOG2   = 3,
    parameter logic [ADDR_WIDTH-1:0] ROM_BASE    = 'hFC00,
    parameter logic [ADDR_WIDTH-1:0] ROM_LIMIT   = 'hFFFF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  bus_req,
    input  logic                  bus_we,
    input  logic [ADDR_WIDTH-1:0] bus_addr,
    input  logic [DATA_WIDTH-1:0] bus_wdata,
    output logic [DATA_WIDTH-1:0] bus_rdata,
    output logic                  bus_ready,
    output logic                  tx_valid,
    output logic [7:0]            tx_data,
    input  logic                  tx_ready,
    output logic                  tx_overflow,
    output logic                  wp_error
);

    localparam logic [ADDR_WIDTH-1:0] STATUS_ADDR = MMIO_BASE + ADDR_WIDTH'(1);
    localparam int                    FIFO_DEPTH  = 1 << FIFO_LOG2;
    // The WAIT state holds for WAIT_STATES cycles, so the counter is loaded
    // with WAIT_STATES-1 and leaves the state at zero.
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DONE} state_t;

    state_t                  state_reg;
    logic [3:0]              wait_cnt_reg;
    logic                    we_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;

    logic [DATA_WIDTH-1:0]   ram [0:(1 << DEPTH_LOG2)-1];
    logic [7:0]              fifo_mem [0:FIFO_DEPTH-1];
    logic [FIFO_LOG2-1:0]    wr_ptr_reg;
    logic [FIFO_LOG2-1:0]    rd_ptr_reg;
    logic [FIFO_LOG2:0]      count_reg;

    logic                    sel_data, sel_status, sel_ram, commit;
    logic                    wp_hit, ram_we;
    logic                    fifo_full, fifo_empty;
    logic                    pop, push_req, push_ok, after_pop_empty;
    logic [7:0]              push_byte;
    logic [FIFO_LOG2:0]      count_next;
    logic [FIFO_LOG2-1:0]    rd_ptr_next;
    logic [7:0]              tx_data_next;
    logic [DEPTH_LOG2-1:0]   addr_idx;

    // Address decode compares the full address, so only the two exact MMIO
    // addresses are kept out of RAM.
    assign sel_data   = (addr_reg == MMIO_BASE);
    assign sel_status = (addr_reg == STATUS_ADDR);
    assign sel_ram    = !sel_data && !sel_status;
    assign addr_idx   = addr_reg[DEPTH_LOG2-1:0];
    assign commit     = (state_reg == ST_DONE);

`ifdef MEM_WRITE_PROTECT_EN
    assign wp_hit = we_reg && sel_ram && (addr_reg >= ROM_BASE) && (addr_reg <= ROM_LIMIT);
`else
    assign wp_hit = 1'b0;
`endif

    assign ram_we = commit && we_reg && sel_ram && !wp_hit;

    // The count never exceeds FIFO_DEPTH, so its MSB is set only when full.
    assign fifo_full  = count_reg[FIFO_LOG2];
    assign fifo_empty = (count_reg == '0);
    assign pop        = !fifo_empty && tx_ready;
    assign push_req   = commit && we_reg && sel_data;
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // still succeeds in that case.
    assign push_ok    = push_req && (!fifo_full || pop);
    assign push_byte  = wdata_reg[7:0];

    assign rd_ptr_next     = rd_ptr_reg + FIFO_LOG2'(pop);
    assign after_pop_empty = fifo_empty || (pop && (count_reg == {{FIFO_LOG2{1'b0}}, 1'b1}));

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop) begin
            count_next = count_reg + 1'b1;
        end else if (!push_ok && pop) begin
            count_next = count_reg - 1'b1;
        end
    end

    // tx_data is a register. The next head is either the byte behind the
    // current head, or the incoming byte when the FIFO would otherwise run dry.
    always_comb begin
        tx_data_next = tx_data;
        if (after_pop_empty) begin
            if (push_ok) begin
                tx_data_next = push_byte;
            end
        end else begin
            tx_data_next = fifo_mem[rd_ptr_next];
        end
    end

    // Storage arrays carry no reset. The write enables depend on state_reg,
    // so an access abandoned by reset can never commit.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[addr_idx] <= wdata_reg;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_reg] <= push_byte;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= 4'd0;
            we_reg       <= 1'b0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            bus_ready    <= 1'b0;
            bus_rdata    <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_valid     <= 1'b0;
            tx_data      <= 8'h00;
            tx_overflow  <= 1'b0;
        end else begin
            bus_ready <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (bus_req) begin
                        we_reg    <= bus_we;
                        addr_reg  <= bus_addr;
                        wdata_reg <= bus_wdata;
                        if (WAIT_STATES > 0) begin
                            state_reg    <= ST_WAIT;
                            wait_cnt_reg <= WAIT_INIT;
                        end else begin
                            state_reg <= ST_DONE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 4'd0) begin
                        state_reg <= ST_DONE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    bus_ready <= 1'b1;
                    if (!we_reg) begin
                        if (sel_data) begin
                            bus_rdata <= '0;
                        end else if (sel_status) begin
                            bus_rdata <= DATA_WIDTH'({tx_overflow, fifo_empty, fifo_full});
                        end else begin
                            bus_rdata <= ram[addr_idx];
                        end
                    end
                    if (we_reg && sel_status) begin
                        tx_overflow <= 1'b0;
                    end
                    if (push_req && !push_ok) begin
                        tx_overflow <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            wr_ptr_reg <= wr_ptr_reg + FIFO_LOG2'(push_ok);
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            tx_valid   <= (count_next != '0);
            tx_data    <= tx_data_next;
        end
    end

`ifdef MEM_WRITE_PROTECT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wp_error <= 1'b0;
        end else begin
            wp_error <= commit && wp_hit;
        end
    end
`else
    assign wp_error = 1'b0;
`endif

endmodule
